rotor_a_ctrl: RTL and testbench
===============================

// Module: rotor_a_ctrl
// PURPOSE
//  Sequencer for the rotor-A forward path. Runs the load phase that writes the
//  64-entry rotor wiring table, then runs encrypt/decrypt streaming. Produces
//  the buffered mode bit (crypt_mode_buf) and the pipeline-valid strobe
//  (encrypt_pipe) that steer the rotor-A input mux, plus the rotor step offset.
//  Sits between the top-level command inputs and the rotor-A table/mux datapath.
// PARAMETERS
//  CODE_W       6   code-word width; table depth = 2**CODE_W
//  OFFSET_INIT  0   rotor offset value after reset and after each load
// PORTS
//  clk            in   1       single clock; all state updates on rising edge
//  rst            in   1       synchronous, active-high reset
//  load           in   1       level; while high, code_in carries one table entry per cycle
//  encrypt        in   1       level; while high, code_in carries one code word per cycle
//  crypt_mode     in   1       0 = encrypt, 1 = decrypt; sampled only at stream start
//  code_in        in   CODE_W  table entry (load) or code word (encrypt)
//  tbl_we         out  1       table write strobe
//  tbl_addr       out  CODE_W  table write address
//  tbl_wdata      out  CODE_W  table write data (registered code_in)
//  crypt_mode_buf out  1       mode latched for the current stream
//  encrypt_pipe   out  1       code word in the mux stage is valid this cycle
//  code_pipe      out  CODE_W  registered code word matching encrypt_pipe
//  rot_offset     out  CODE_W  current rotor step offset
//  table_ready    out  1       all 2**CODE_W entries written since the last reset/load
//  err_unloaded   out  1       sticky; encrypt was seen while table_ready=0
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): every output = 0, rot_offset = OFFSET_INIT,
//   state = IDLE. Reset in any state aborts the operation and discards the table.
//  FSM states: IDLE, LOAD, READY, CRYPT.
//   IDLE : load=1 -> LOAD. encrypt=1 -> set err_unloaded, stay in IDLE.
//   LOAD : Each cycle with load=1: tbl_we=1 on the next cycle, tbl_addr = entry
//          count, tbl_wdata = code_in (1-cycle write latency). Entry 2**CODE_W-1
//          written -> table_ready=1, rot_offset=OFFSET_INIT, -> READY.
//          load drops early -> table_ready stays 0, -> IDLE (partial table).
//   READY: load=1 -> LOAD; table_ready cleared on entry; count restarts at 0.
//          encrypt=1 -> latch crypt_mode into crypt_mode_buf, -> CRYPT.
//   CRYPT: Each cycle with encrypt=1: next cycle encrypt_pipe=1 and
//          code_pipe = code_in. rot_offset increments by 1 (mod 2**CODE_W;
//          63 wraps to 0) on the same edge, in both modes.
//          encrypt=0 -> READY. crypt_mode_buf holds until the next stream start.
//  Priority: load beats encrypt whenever both are high (READY/CRYPT -> LOAD;
//   the in-flight word still completes its encrypt_pipe cycle).
//  crypt_mode changes during CRYPT are ignored.
//  Latency: code_in to code_pipe/encrypt_pipe is 1 cycle. Throughput is 1 word
//   per cycle. No backpressure.
//  err_unloaded is cleared only by rst.
// STRUCTURE
//  Shared package enigma_pkg holds: CODE_W localparam, the state enum
//   {IDLE, LOAD, READY, CRYPT}, and MODE_ENC=0 / MODE_DEC=1 constants.
//  One sub-module is natural: rotor_step_ctr (modulo-2**CODE_W offset counter
//   with synchronous clear-to-init and an increment enable).
//  All remaining logic is a single FSM plus the output registers.
// TESTING
//  1) rst 2 cycles, then load=1 for 64 cycles with code_in=63-i ->
//     tbl_we is seen 64 times, addr 0..63, data 63..0; table_ready=1 one cycle
//     after the last entry; rot_offset=0.
//  2) After load, encrypt=1 for 3 cycles, crypt_mode=0, code_in=5,6,7 ->
//     encrypt_pipe=1 on cycles +1..+3, code_pipe=5,6,7, crypt_mode_buf=0,
//     rot_offset=3.
//  3) 66 consecutive encrypt words in decrypt mode -> crypt_mode_buf=1
//     throughout; rot_offset wraps 63->0 and ends at 2.
//  4) encrypt=1 immediately after reset (no load) -> encrypt_pipe stays 0,
//     err_unloaded=1 and stays set until rst.
//  5) load drops after 10 entries -> table_ready=0 and state IDLE; a
//     following encrypt sets err_unloaded.
//  6) rst asserted mid-CRYPT and mid-LOAD -> next cycle all outputs 0,
//     table_ready=0, rot_offset=OFFSET_INIT; load and encrypt high together
//     in READY -> LOAD is entered and no encrypt_pipe is produced.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the rotor-A control path.
package enigma_pkg;

    localparam int unsigned CODE_W = 6;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        CRYPT = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/rotor_step_ctr.sv
// Modulo-2**WIDTH rotor step offset counter with sync clear-to-init and increment enable.
module rotor_step_ctr #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] offset
);

    // Natural wrap of the WIDTH-bit add gives the modulo step.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            offset <= WIDTH'(INIT);
        end else if (inc) begin
            offset <= offset + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rotor_a_ctrl.sv
// Rotor-A forward path sequencer: wiring-table load, then encrypt/decrypt streaming.
module rotor_a_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned CODE_W      = enigma_pkg::CODE_W,
    parameter int unsigned OFFSET_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              encrypt,
    input  logic              crypt_mode,
    input  logic [CODE_W-1:0] code_in,
    output logic              tbl_we,
    output logic [CODE_W-1:0] tbl_addr,
    output logic [CODE_W-1:0] tbl_wdata,
    output logic              crypt_mode_buf,
    output logic              encrypt_pipe,
    output logic [CODE_W-1:0] code_pipe,
    output logic [CODE_W-1:0] rot_offset,
    output logic              table_ready,
    output logic              err_unloaded
);

    localparam logic [CODE_W-1:0] LAST_ADDR = {CODE_W{1'b1}};

    ctrl_state_e       state;
    logic [CODE_W-1:0] load_cnt;
    logic              step_clr_c;
    logic              step_inc_c;

    // Offset steps once per accepted stream word; load beats take priority.
    always_comb begin
        step_clr_c = 1'b0;
        step_inc_c = 1'b0;
        if ((state == LOAD) && load && (load_cnt == LAST_ADDR)) begin
            step_clr_c = 1'b1;
        end
        if (((state == READY) || (state == CRYPT)) && encrypt && !load) begin
            step_inc_c = 1'b1;
        end
    end

    rotor_step_ctr #(
        .WIDTH (CODE_W),
        .INIT  (OFFSET_INIT)
    ) u_step_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (step_clr_c),
        .inc    (step_inc_c),
        .offset (rot_offset)
    );

    // Sequencer and registered outputs; the beat that starts a load is entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            load_cnt       <= '0;
            tbl_we         <= 1'b0;
            tbl_addr       <= '0;
            tbl_wdata      <= '0;
            crypt_mode_buf <= MODE_ENC;
            encrypt_pipe   <= 1'b0;
            code_pipe      <= '0;
            table_ready    <= 1'b0;
            err_unloaded   <= 1'b0;
        end else begin
            tbl_we       <= 1'b0;
            encrypt_pipe <= 1'b0;

            if (encrypt && !table_ready) begin
                err_unloaded <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        tbl_we    <= 1'b1;
                        tbl_addr  <= '0;
                        tbl_wdata <= code_in;
                        load_cnt  <= CODE_W'(1);
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    if (load) begin
                        tbl_we    <= 1'b1;
                        tbl_addr  <= load_cnt;
                        tbl_wdata <= code_in;
                        load_cnt  <= load_cnt + CODE_W'(1);
                        if (load_cnt == LAST_ADDR) begin
                            table_ready <= 1'b1;
                            state       <= READY;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                READY, CRYPT: begin
                    if (load) begin
                        tbl_we      <= 1'b1;
                        tbl_addr    <= '0;
                        tbl_wdata   <= code_in;
                        load_cnt    <= CODE_W'(1);
                        table_ready <= 1'b0;
                        state       <= LOAD;
                    end else if (encrypt) begin
                        encrypt_pipe <= 1'b1;
                        code_pipe    <= code_in;
                        if (state == READY) begin
                            crypt_mode_buf <= (crypt_mode == MODE_DEC) ? MODE_DEC : MODE_ENC;
                        end
                        state <= CRYPT;
                    end else begin
                        state <= READY;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_a_ctrl.sv
// Self-checking bench for rotor_a_ctrl: vector table plus write/pipe scoreboards.
module tb_rotor_a_ctrl;

    localparam int unsigned W = 6;

    logic         clk;
    logic         rst;
    logic         load;
    logic         encrypt;
    logic         crypt_mode;
    logic [W-1:0] code_in;
    logic         tbl_we;
    logic [W-1:0] tbl_addr;
    logic [W-1:0] tbl_wdata;
    logic         crypt_mode_buf;
    logic         encrypt_pipe;
    logic [W-1:0] code_pipe;
    logic [W-1:0] rot_offset;
    logic         table_ready;
    logic         err_unloaded;

    rotor_a_ctrl #(
        .CODE_W      (W),
        .OFFSET_INIT (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load           (load),
        .encrypt        (encrypt),
        .crypt_mode     (crypt_mode),
        .code_in        (code_in),
        .tbl_we         (tbl_we),
        .tbl_addr       (tbl_addr),
        .tbl_wdata      (tbl_wdata),
        .crypt_mode_buf (crypt_mode_buf),
        .encrypt_pipe   (encrypt_pipe),
        .code_pipe      (code_pipe),
        .rot_offset     (rot_offset),
        .table_ready    (table_ready),
        .err_unloaded   (err_unloaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [W-1:0] code;
        logic         mode;
        logic [W-1:0] off;
    } pp_t;

    typedef struct packed {
        logic         r;
        logic         l;
        logic         e;
        logic         m;
        logic [W-1:0] code;
        logic         we;
        logic         pipe;
        logic         rdy;
        logic         err;
        logic [W-1:0] off;
        logic         mbuf;
    } vec_t;

    wr_t  wq[$];
    pp_t  pq[$];
    vec_t vecs[9];

    int n_tests = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int exp_off = 0;
    bit sb_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic l, input logic e, input logic m,
                         input logic [W-1:0] c);
        rst        = r;
        load       = l;
        encrypt    = e;
        crypt_mode = m;
        code_in    = c;
    endtask

    // Advance one clock and score any table write / pipe word the DUT presents.
    task automatic tick();
        wr_t w;
        pp_t p;
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (tbl_we) begin
                n_we++;
                if (wq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tbl_we_unexpected: got write addr %0d, expected no write", tbl_addr);
                end else begin
                    w = wq.pop_front();
                    check("tbl_addr", 32'(tbl_addr), 32'(w.addr));
                    check("tbl_wdata", 32'(tbl_wdata), 32'(w.data));
                end
            end
            if (encrypt_pipe) begin
                if (pq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pipe_unexpected: got code_pipe %0d, expected no valid word", code_pipe);
                end else begin
                    p = pq.pop_front();
                    check("code_pipe", 32'(code_pipe), 32'(p.code));
                    check("crypt_mode_buf", 32'(crypt_mode_buf), 32'(p.mode));
                    check("rot_offset_step", 32'(rot_offset), 32'(p.off));
                end
            end
            check("wr_pending", 32'(wq.size()), 32'd0);
            check("pipe_pending", 32'(pq.size()), 32'd0);
        end
    endtask

    task automatic load_table(input int n, input bit rev);
        logic [W-1:0] c;
        for (int i = 0; i < n; i++) begin
            c = rev ? W'(63 - i) : W'($urandom);
            drive(1'b0, 1'b1, 1'b0, 1'b0, c);
            wq.push_back('{addr: W'(i), data: c});
            tick();
            check($sformatf("ready_beat%0d", i), 32'(table_ready), (i == 63) ? 32'd1 : 32'd0);
        end
        if (n == 64) exp_off = 0;
    endtask

    task automatic enc_word(input logic m, input logic [W-1:0] c, input logic exp_mode);
        drive(1'b0, 1'b0, 1'b1, m, c);
        exp_off = (exp_off + 1) % 64;
        pq.push_back('{code: c, mode: exp_mode, off: W'(exp_off)});
        tick();
    endtask

    function automatic vec_t mk(input logic r, input logic l, input logic e, input logic m,
                                input logic [W-1:0] c, input logic we, input logic pipe,
                                input logic rdy, input logic err);
        vec_t v;
        v.r = r; v.l = l; v.e = e; v.m = m; v.code = c;
        v.we = we; v.pipe = pipe; v.rdy = rdy; v.err = err;
        v.off = '0; v.mbuf = 1'b0;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(tbl_we), 32'd0);
        check({tag, "_addr"}, 32'(tbl_addr), 32'd0);
        check({tag, "_wdata"}, 32'(tbl_wdata), 32'd0);
        check({tag, "_mbuf"}, 32'(crypt_mode_buf), 32'd0);
        check({tag, "_pipe"}, 32'(encrypt_pipe), 32'd0);
        check({tag, "_code_pipe"}, 32'(code_pipe), 32'd0);
        check({tag, "_offset"}, 32'(rot_offset), 32'd0);
        check({tag, "_ready"}, 32'(table_ready), 32'd0);
        check({tag, "_err"}, 32'(err_unloaded), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Reset, encrypt with no table, a stray load beat, reset clears the sticky error.
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd9,  1'b0, 1'b0, 1'b0, 1'b1);
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        vecs[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, 6'd3,  1'b1, 1'b0, 1'b0, 1'b1);
        vecs[6] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        vecs[7] = mk(1'b1, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8] = mk(1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].l, vecs[k].e, vecs[k].m, vecs[k].code);
            tick();
            check($sformatf("vec%0d_we", k), 32'(tbl_we), 32'(vecs[k].we));
            check($sformatf("vec%0d_pipe", k), 32'(encrypt_pipe), 32'(vecs[k].pipe));
            check($sformatf("vec%0d_ready", k), 32'(table_ready), 32'(vecs[k].rdy));
            check($sformatf("vec%0d_err", k), 32'(err_unloaded), 32'(vecs[k].err));
            check($sformatf("vec%0d_offset", k), 32'(rot_offset), 32'(vecs[k].off));
            check($sformatf("vec%0d_mbuf", k), 32'(crypt_mode_buf), 32'(vecs[k].mbuf));
        end

        sb_on   = 1'b1;
        exp_off = 0;

        // Full load, reversed data.
        n_we = 0;
        load_table(64, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("load_we_count", 32'(n_we), 32'd64);
        check("load_ready", 32'(table_ready), 32'd1);
        check("load_offset", 32'(rot_offset), 32'd0);
        check("load_err", 32'(err_unloaded), 32'd0);

        // Short encrypt stream; mode flips after the start are ignored.
        enc_word(1'b0, 6'd5, 1'b0);
        enc_word(1'b1, 6'd6, 1'b0);
        enc_word(1'b1, 6'd7, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("enc3_offset", 32'(rot_offset), 32'd3);
        check("enc3_pipe_idle", 32'(encrypt_pipe), 32'd0);
        check("enc3_mbuf", 32'(crypt_mode_buf), 32'd0);
        check("enc3_ready", 32'(table_ready), 32'd1);

        // Reload from READY, then 66 decrypt words wrapping the offset.
        load_table(64, 1'b0);
        check("reload_offset", 32'(rot_offset), 32'd0);
        for (int k = 0; k < 66; k++) begin
            enc_word((k == 0) ? 1'b1 : 1'($urandom_range(0, 1)), W'($urandom), 1'b1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("dec66_offset", 32'(rot_offset), 32'd2);
        check("dec66_mbuf", 32'(crypt_mode_buf), 32'd1);

        // Partial load leaves an unusable table; encrypt afterwards flags the error.
        load_table(10, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("partial_ready", 32'(table_ready), 32'd0);
        check("partial_err_before", 32'(err_unloaded), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd12);
        tick();
        check("partial_err", 32'(err_unloaded), 32'd1);
        check("partial_pipe", 32'(encrypt_pipe), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("partial_err_sticky", 32'(err_unloaded), 32'd1);

        // Full load does not clear the sticky error; reset mid-CRYPT clears everything.
        load_table(64, 1'b0);
        check("err_survives_load", 32'(err_unloaded), 32'd1);
        enc_word(1'b1, 6'd40, 1'b1);
        enc_word(1'b1, 6'd41, 1'b1);
        enc_word(1'b0, 6'd42, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd43);
        tick();
        check_all_zero("rst_crypt");
        exp_off = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        // Reset mid-LOAD.
        load_table(20, 1'b0);
        check("midload_addr", 32'(tbl_addr), 32'd19);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'd50);
        tick();
        check_all_zero("rst_load");
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        // load and encrypt together after a word: load wins, in-flight word already out.
        load_table(64, 1'b1);
        enc_word(1'b0, 6'd33, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd44);
        wq.push_back('{addr: 6'd0, data: 6'd44});
        tick();
        check("both_pipe", 32'(encrypt_pipe), 32'd0);
        check("both_ready", 32'(table_ready), 32'd0);
        check("both_offset", 32'(rot_offset), 32'd1);
        check("both_err", 32'(err_unloaded), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        check("both_we_drop", 32'(tbl_we), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 6'd45);
        tick();
        check("both_then_err", 32'(err_unloaded), 32'd1);
        check("both_then_pipe", 32'(encrypt_pipe), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
